// File: rtl/bb_ram_arb.sv
// Round-robin arbiter sharing the single-port bb_ram among NREQ requesters, with lock for RMW sequences.
// Optional macro BB_ARB_PRIO0_EN gives requester 0 fixed priority over the round-robin ring.
module bb_ram_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 11
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_lock_i,
  input  logic [4*NREQ-1:0] req_we_i,
  input  logic [AW*NREQ-1:0] req_addr_i,
  input  logic [32*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_we_o,
  output logic              ram_en_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win;
  logic [AW-1:0]   addr_q, addr_d, win_addr;
  logic [31:0]     wdata_q, wdata_d, win_wdata;
  logic [NREQ-1:0] rsp_q, rsp_d;
  logic [3:0]      win_we;
  logic            win_lock, found, xfer;
  int              idx;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + PW'(1);
  endfunction

  // Winner selection: the owner alone while locked, else a scan from ptr with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (state_q == LOCKED) begin
      found = req_valid_i[owner_q];
      win   = owner_q;
    end else begin
`ifdef BB_ARB_PRIO0_EN
      if (req_valid_i[0]) found = 1'b1;
`endif
      for (int j = 0; j < NREQ; j++) begin
        idx = int'(ptr_q) + j;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req_valid_i[idx]) begin
          found = 1'b1;
          win   = PW'(idx);
        end
      end
    end
  end

  assign xfer      = reset_i & found;
  assign win_we    = req_we_i[int'(win)*4 +: 4];
  assign win_addr  = req_addr_i[int'(win)*AW +: AW];
  assign win_wdata = req_wdata_i[int'(win)*32 +: 32];
  assign win_lock  = req_lock_i[win];

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[win] = 1'b1;
  end

  // Address/data hold their last driven values between transfers.
  assign ram_addr_o  = !reset_i ? '0 : (xfer ? win_addr : addr_q);
  assign ram_wdata_o = !reset_i ? '0 : (xfer ? win_wdata : wdata_q);
  assign ram_we_o    = xfer ? win_we : 4'b0000;
  assign ram_en_o    = xfer && (win_we == 4'b0000);
  assign rsp_valid_o = rsp_q & {NREQ{reset_i}};
  assign rsp_rdata_o = ram_rdata_i;
  assign addr_d      = xfer ? win_addr : addr_q;
  assign wdata_d     = xfer ? win_wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rsp_d   = '0;
    if (xfer) begin
      if (win_we == 4'b0000) rsp_d[win] = 1'b1;
      if (state_q == UNLOCKED) begin
        if (win_lock) begin
          state_d = LOCKED;
          owner_d = win;
        end else begin
          ptr_d = inc(win);
`ifdef BB_ARB_PRIO0_EN
          if (win == '0) ptr_d = ptr_q;
`endif
        end
      end else if (!win_lock) begin
        state_d = UNLOCKED;
        ptr_d   = inc(owner_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= UNLOCKED;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end
endmodule

// File: doc/bb_ram_arb.md
# bb_ram_arb

Round-robin arbiter that shares the single-port 8 KB, 32-bit byte-enabled `bb_ram` buffer between up to NREQ requesters (cores and the Ethernet DMA engine). It selects one request per cycle and drives the RAM address, data, byte-enable and read-enable inputs. It also returns read data with a per-requester valid strobe. A lock mechanism gives one requester back-to-back exclusive access for read-modify-write sequences.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 11, word-address width (byte address bits 12:2)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_lock  in  NREQ  keep the grant after this transfer
- req_we  in  4*NREQ  byte enables; requester i uses [4i+3:4i]; 0000 means read
- req_addr  in  AW*NREQ  word address; requester i uses [AW*i+AW-1:AW*i]
- req_wdata  in  32*NREQ  write data; requester i uses [32i+31:32i]
- req_ready  out  NREQ  one-hot accept; a transfer occurs when valid[i] and ready[i] are both high
- rsp_valid  out  NREQ  one-hot read-data strobe
- rsp_rdata  out  32  read data; qualified by rsp_valid
- ram_addr  out  AW  to RAM address
- ram_wdata  out  32  to RAM data_in
- ram_we  out  4  to RAM byte write enables
- ram_en  out  1  to RAM read enable
- ram_rdata  in  32  from RAM data_out

## Operation
**Arbitration (UNLOCKED state)**
- Register `ptr` (0..NREQ-1) holds the highest-priority requester.
- The winner is the first i with req_valid[i] set, scanning ptr, ptr+1, … with wrap modulo NREQ.
- After each transfer, ptr becomes winner+1 mod NREQ.

**Grant and RAM drive**
- req_ready[winner] is combinational, so a transfer happens in the same cycle.
- In that cycle, ram_addr and ram_wdata are driven from the winner.
- ram_we = req_we of the winner.
- ram_en = 1 only if req_we == 0000.
- With no transfer: ram_we = 0000, ram_en = 0, and ram_addr/ram_wdata hold their last values.

**Lock (LOCKED state, register `owner`)**
- A transfer with req_lock[i]=1 moves the FSM UNLOCKED→LOCKED and sets owner=i. ptr is not advanced.
- In LOCKED, only owner can receive req_ready; every other requester is stalled.
- A transfer by owner with req_lock=0 returns the FSM to UNLOCKED and sets ptr=owner+1.
- If owner drops req_valid, the FSM stays LOCKED.

**Responses**
- A read accepted in cycle N sets rsp_valid[i] in cycle N+1.
- rsp_rdata = ram_rdata, passed through combinationally.
- Writes produce no response.
- Back-to-back reads produce back-to-back strobes, one per cycle.

**Reset values (while reset=0)**
- req_ready=0, ram_we=0000, ram_en=0, rsp_valid=0.
- ram_addr=0 and ram_wdata=0.
- ptr=0, FSM=UNLOCKED.
- rsp_rdata follows ram_rdata.

## Timing
- Grant latency: 0 cycles (combinational from req_valid).
- Read latency: 1 cycle, transfer edge to rsp_valid.
- Throughput: 1 transfer per cycle; no bubble between different requesters.
- Requesters hold addr, we, wdata and lock stable while valid is high and ready is low.
- Simultaneous requests: exactly one ready bit per cycle; the others wait.
- Reset asserted in the cycle after a read is accepted: the response is dropped and rsp_valid stays 0.
- Reset asserted in the same cycle as a request: no transfer occurs.
- Reset asserted during LOCKED: the FSM returns to UNLOCKED.

## Configuration
- BB_ARB_PRIO0_EN defined:
  - In UNLOCKED, requester 0 wins whenever req_valid[0]=1, regardless of ptr.
  - Requester 0 wins do not advance ptr.
  - Other requesters use round-robin.
  - LOCKED behaviour is unchanged.
- BB_ARB_PRIO0_EN undefined: pure round-robin as described above.

## Test plan
- Reset then idle:
  - Hold reset=0 for 3 cycles with all req_valid=1 → req_ready=0, ram_en=0, ram_we=0000, rsp_valid=0 throughout.
  - After release, ptr=0, so requester 0 is granted first.
- Single requester write then read:
  - Requester 2 writes 0xDEADBEEF to addr 0x010 with we=1111.
  - In the next cycle it reads addr 0x010.
  - Expect rsp_valid=0100 one cycle later with rsp_rdata=0xDEADBEEF.
- Round-robin fairness:
  - All 4 requesters hold valid for 8 cycles.
  - Grants go 0,1,2,3,0,1,2,3, one per cycle.
  - Each read strobe appears one cycle after its grant.
- Byte enables:
  - Write 0x11223344 with we=0010 to an address holding 0x00000000.
  - A read returns 0x00003300.
- Lock:
  - Requester 1 reads with lock=1 while requesters 0, 2 and 3 are valid; in the next cycle it writes with lock=0.
  - Expect two consecutive grants to 1, then the next grant to 2.
  - With requester 1 idle while LOCKED for 5 cycles, no grants occur.
- BB_ARB_PRIO0_EN build:
  - Requesters 0 and 3 are continuously valid with ptr=3.
  - Requester 0 is granted every cycle; requester 3 is never granted.
  - Without the macro, grants alternate 3,0,3,0.
